// File: rtl/fc_argmax_10_pkg.sv
// Shared definitions for the 10-class argmax classifier.
//   NUM_CLASSES : number of class scores scanned per frame
//   IDX_WIDTH   : width of a class index (0..9)
//   state_t     : scan controller states
package fc_argmax_10_pkg;

    localparam int unsigned NUM_CLASSES = 10;
    localparam int unsigned IDX_WIDTH   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/fc_argmax_10_score_gt.sv
// score_gt: combinational "a strictly greater than b" for class scores.
// Parameters:
//   DATA_WIDTH : score width
//   ARITH_TYPE : 0 = two's-complement signed, 1 = IEEE-754 single (DATA_WIDTH = 32)
// Ports:
//   a, b   : scores to compare
//   a_gt_b : 1 when a > b; in float mode +0 == -0 and any NaN gives 0
module score_gt #(
    parameter int DATA_WIDTH = 32,
    parameter int ARITH_TYPE = 0
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  a_gt_b
);

    if (ARITH_TYPE == 1) begin : g_float
        logic        a_nan;
        logic        b_nan;
        logic        both_zero;
        logic [31:0] key_a;
        logic [31:0] key_b;

        assign a_nan     = (&a[30:23]) && (|a[22:0]);
        assign b_nan     = (&b[30:23]) && (|b[22:0]);
        assign both_zero = ~(|a[30:0]) && ~(|b[30:0]);

        // Map sign-magnitude onto an unsigned-monotonic key: negatives are
        // inverted, positives get the top bit set. Only +0/-0 disagree with
        // float ordering, and that case is caught by both_zero.
        assign key_a = a[31] ? ~a : {1'b1, a[30:0]};
        assign key_b = b[31] ? ~b : {1'b1, b[30:0]};

        assign a_gt_b = ~a_nan && ~b_nan && ~both_zero && (key_a > key_b);
    end else begin : g_signed
        assign a_gt_b = $signed(a) > $signed(b);
    end

endmodule

// File: rtl/fc_argmax_10.sv
// fc_argmax_10: picks the index of the largest of ten class scores.
// A start pulse in IDLE captures Data_in_1..Data_in_10 into a local bank, then one
// score is compared per cycle; the result is held until class_valid && class_ready.
// Parameters:
//   DATA_WIDTH : score width
//   ARITH_TYPE : 0 = signed fixed point, 1 = IEEE-754 single (DATA_WIDTH = 32)
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   start                 : one-cycle frame start, scores valid in that cycle
//   Data_in_1..Data_in_10 : class scores 0..9
//   busy                  : scan in progress
//   class_valid           : result available
//   class_ready           : consumer accepts the result
//   class_score           : winning score (only with macro ARGMAX_SCORE_OUT_EN)
//   class_idx             : winning class 0..9
module fc_argmax_10
    import fc_argmax_10_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ARITH_TYPE = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] Data_in_1,
    input  logic [DATA_WIDTH-1:0] Data_in_2,
    input  logic [DATA_WIDTH-1:0] Data_in_3,
    input  logic [DATA_WIDTH-1:0] Data_in_4,
    input  logic [DATA_WIDTH-1:0] Data_in_5,
    input  logic [DATA_WIDTH-1:0] Data_in_6,
    input  logic [DATA_WIDTH-1:0] Data_in_7,
    input  logic [DATA_WIDTH-1:0] Data_in_8,
    input  logic [DATA_WIDTH-1:0] Data_in_9,
    input  logic [DATA_WIDTH-1:0] Data_in_10,
    output logic                  busy,
    output logic                  class_valid,
    input  logic                  class_ready,
`ifdef ARGMAX_SCORE_OUT_EN
    output logic [DATA_WIDTH-1:0] class_score,
`endif
    output logic [IDX_WIDTH-1:0]  class_idx
);

    state_t                 state_q, state_d;
    logic [IDX_WIDTH-1:0]   cnt_q, cnt_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic [DATA_WIDTH-1:0]  cand_q, cand_d;
    logic [DATA_WIDTH-1:0]  bank_q [NUM_CLASSES];
    logic [DATA_WIDTH-1:0]  din    [NUM_CLASSES];
    logic [DATA_WIDTH-1:0]  cur_score;
    logic                   load_bank;
    logic                   cur_gt;

    assign din[0] = Data_in_1;
    assign din[1] = Data_in_2;
    assign din[2] = Data_in_3;
    assign din[3] = Data_in_4;
    assign din[4] = Data_in_5;
    assign din[5] = Data_in_6;
    assign din[6] = Data_in_7;
    assign din[7] = Data_in_8;
    assign din[8] = Data_in_9;
    assign din[9] = Data_in_10;

    assign cur_score = bank_q[cnt_q];

    score_gt #(
        .DATA_WIDTH (DATA_WIDTH),
        .ARITH_TYPE (ARITH_TYPE)
    ) u_score_gt (
        .a      (cur_score),
        .b      (cand_q),
        .a_gt_b (cur_gt)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        cand_d    = cand_q;
        load_bank = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load_bank = 1'b1;
                    cand_d    = Data_in_1;
                    idx_d     = '0;
                    cnt_d     = IDX_WIDTH'(1);
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                // Strict compare keeps the lowest index on ties.
                if (cur_gt) begin
                    cand_d = cur_score;
                    idx_d  = cnt_q;
                end
                if (cnt_q == IDX_WIDTH'(NUM_CLASSES - 1)) begin
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + IDX_WIDTH'(1);
                end
            end
            HOLD: begin
                if (class_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            cand_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            cand_q  <= cand_d;
        end
    end

    // Bank contents are only meaningful after a start, so it needs no reset.
    always_ff @(posedge clk) begin
        if (!reset && load_bank) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                bank_q[i] <= din[i];
            end
        end
    end

    assign busy        = (state_q == SCAN);
    assign class_valid = (state_q == HOLD);
    assign class_idx   = idx_q;
`ifdef ARGMAX_SCORE_OUT_EN
    assign class_score = cand_q;
`endif

endmodule

// File: tb/tb_fc_argmax_10.sv
// Directed bench for fc_argmax_10: one signed instance and one float instance
// share clock and control; each gets its own score vector.
module tb_fc_argmax_10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        class_ready;
    logic [31:0] d_int [10];
    logic [31:0] d_flt [10];
    logic        busy_i, valid_i, busy_f, valid_f;
    logic [3:0]  idx_i, idx_f;
`ifdef ARGMAX_SCORE_OUT_EN
    logic [31:0] score_i, score_f;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fc_argmax_10 #(.DATA_WIDTH(32), .ARITH_TYPE(0)) u_dut_int (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .Data_in_1   (d_int[0]),
        .Data_in_2   (d_int[1]),
        .Data_in_3   (d_int[2]),
        .Data_in_4   (d_int[3]),
        .Data_in_5   (d_int[4]),
        .Data_in_6   (d_int[5]),
        .Data_in_7   (d_int[6]),
        .Data_in_8   (d_int[7]),
        .Data_in_9   (d_int[8]),
        .Data_in_10  (d_int[9]),
        .busy        (busy_i),
        .class_valid (valid_i),
        .class_ready (class_ready),
`ifdef ARGMAX_SCORE_OUT_EN
        .class_score (score_i),
`endif
        .class_idx   (idx_i)
    );

    fc_argmax_10 #(.DATA_WIDTH(32), .ARITH_TYPE(1)) u_dut_flt (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .Data_in_1   (d_flt[0]),
        .Data_in_2   (d_flt[1]),
        .Data_in_3   (d_flt[2]),
        .Data_in_4   (d_flt[3]),
        .Data_in_5   (d_flt[4]),
        .Data_in_6   (d_flt[5]),
        .Data_in_7   (d_flt[6]),
        .Data_in_8   (d_flt[7]),
        .Data_in_9   (d_flt[8]),
        .Data_in_10  (d_flt[9]),
        .busy        (busy_f),
        .class_valid (valid_f),
        .class_ready (class_ready),
`ifdef ARGMAX_SCORE_OUT_EN
        .class_score (score_f),
`endif
        .class_idx   (idx_f)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called 1ns after an edge; start is sampled on the next edge.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts edges after the start edge until class_valid; optionally pokes start
    // (which must be ignored) in the cycle before edge number poke.
    task automatic wait_valid(input int poke, output int lat);
        lat = 99;
        for (int k = 1; k <= 20; k++) begin
            if (k == poke) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            if (valid_i) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_frame(input string tag, input logic [3:0] exp_idx,
                             input logic [31:0] exp_score, input int poke);
        int lat;
        pulse_start();
        check_eq({tag, "_busy"}, 32'(busy_i), 32'd1);
        wait_valid(poke, lat);
        check_eq({tag, "_latency"}, 32'(lat), 32'd9);
        check_eq({tag, "_idx"}, 32'(idx_i), 32'(exp_idx));
        check_eq({tag, "_flt_idx"}, 32'(idx_f), 32'd5);
`ifdef ARGMAX_SCORE_OUT_EN
        check_eq({tag, "_score"}, score_i, exp_score);
        check_eq({tag, "_flt_score"}, score_f, 32'h3E80_0000);
`else
        if (exp_score == 32'hDEAD_BEEF) $display("note: unused score marker");
`endif
    endtask

    task automatic accept(input string tag);
        class_ready = 1'b1;
        @(posedge clk); #1;
        class_ready = 1'b0;
        check_eq({tag, "_accepted"}, 32'(valid_i), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b1;
        start       = 1'b1;
        class_ready = 1'b0;
        d_int = '{32'd5, -32'sd3, 32'd12, 32'd7, 32'd12, 32'd0, -32'sd1, 32'd2, 32'd11, 32'd4};
        // -1.0, -0.5, +0, -0, NaN, 0.25, -2.0, 0.25, 1e-3, -0
        d_flt = '{32'hBF80_0000, 32'hBF00_0000, 32'h0000_0000, 32'h8000_0000, 32'h7FC0_0000,
                  32'h3E80_0000, 32'hC000_0000, 32'h3E80_0000, 32'h3A83_126F, 32'h8000_0000};

        // Reset with start held high: start must be ignored.
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy_i), 32'd0);
        check_eq("rst_valid", 32'(valid_i), 32'd0);
        check_eq("rst_idx", 32'(idx_i), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        check_eq("post_rst_busy", 32'(busy_i), 32'd0);

        // Tie between index 2 and 4 goes to 2.
        run_frame("tie", 4'd2, 32'd12, 0);
        accept("tie");

        d_int = '{10{32'h8000_0000}};
        run_frame("allmin", 4'd0, 32'h8000_0000, 0);
        accept("allmin");

        d_int = '{10{32'hFFFF_FFFF}};
        run_frame("allneg1", 4'd0, 32'hFFFF_FFFF, 0);
        accept("allneg1");

        // Signedness: most negative vs most positive.
        d_int = '{32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 32'd0, 32'd0,
                  32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        run_frame("sign", 4'd1, 32'h7FFF_FFFF, 0);
        accept("sign");

        // Stall in HOLD with start pokes in SCAN and HOLD.
        d_int = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd99, -32'sd5, 32'd98, 32'd0};
        run_frame("stall", 4'd6, 32'd99, 3);
        for (int c = 0; c < 7; c++) begin
            start = c[0];
            @(posedge clk); #1;
            start = 1'b0;
            check_eq("stall_valid", 32'(valid_i), 32'd1);
            check_eq("stall_idx", 32'(idx_i), 32'd6);
            check_eq("stall_busy", 32'(busy_i), 32'd0);
        end
        class_ready = 1'b1;
        start       = 1'b1;
        @(posedge clk); #1;
        class_ready = 1'b0;
        start       = 1'b0;
        check_eq("hs_valid", 32'(valid_i), 32'd0);
        check_eq("hs_busy", 32'(busy_i), 32'd0);
        @(posedge clk); #1;
        check_eq("hs_idle_busy", 32'(busy_i), 32'd0);

        // Reset in the middle of a scan, start asserted alongside reset.
        d_int = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9};
        pulse_start();
        repeat (4) @(posedge clk);
        #1;
        check_eq("midscan_idx", 32'(idx_i), 32'd4);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        check_eq("midrst_busy", 32'(busy_i), 32'd0);
        check_eq("midrst_valid", 32'(valid_i), 32'd0);
        check_eq("midrst_idx", 32'(idx_i), 32'd0);
        @(posedge clk); #1;
        check_eq("midrst_idle", 32'(busy_i), 32'd0);
        run_frame("after_rst", 4'd9, 32'd9, 0);
        accept("after_rst");

        // Back-to-back frames with class_ready tied high.
        class_ready = 1'b1;
        d_int = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd100, 32'd0, 32'd0, 32'd0, 32'd0};
        run_frame("b2b_a", 4'd5, 32'd100, 0);
        @(posedge clk); #1;
        check_eq("b2b_a_accept", 32'(valid_i), 32'd0);
        d_int = '{-32'sd10, -32'sd20, -32'sd30, -32'sd40, -32'sd50,
                  -32'sd60, -32'sd70, -32'sd80, -32'sd90, -32'sd5};
        run_frame("b2b_b", 4'd9, 32'hFFFF_FFFB, 0);
        @(posedge clk); #1;
        check_eq("b2b_b_accept", 32'(valid_i), 32'd0);
        class_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
